usb_token_rx: RTL

Sequential USB token-packet receiver for the endpoint transaction layer. Accepts the de-stuffed byte stream from the packet layer one byte per cycle and assembles 3-byte OUT/IN/SETUP/SOF tokens. It checks the PID complement, CRC5, length and inter-byte timeout, then filters on device address and a parametrised endpoint count. Accepted tokens are delivered as a registered one-cycle strobe with decoded fields and a one-hot endpoint select.

---
 rtl/usb_token_rx.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/usb_token_rx.sv
// USB token-packet receiver: assembles 3-byte OUT/IN/SETUP/SOF tokens from the
// de-stuffed byte stream, validates PID/CRC5/length/timing and filters on address/endpoint.
module usb_token_rx #(
  parameter int NUM_EP  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  input  logic              rx_eop,
  input  logic [6:0]        dev_addr,
  output logic              tok_valid,
  output logic [3:0]        tok_pid,
  output logic [6:0]        tok_addr,
  output logic [3:0]        tok_endp,
  output logic [10:0]       tok_frame,
  output logic              tok_sof,
  output logic [NUM_EP-1:0] tok_ep_sel,
  output logic              err_pid,
  output logic              err_crc,
  output logic              err_len,
  output logic              err_endp,
  output logic              err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    CRC   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // CRC5 (x^5+x^2+1, seed all-ones) over 11 bits in wire order, returned complemented
  function automatic logic [4:0] crc5_calc(input logic [10:0] data);
    logic [4:0] c;
    logic       fb;
    c = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      fb = c[4] ^ data[i];
      c  = fb ? ({c[3:0], 1'b0} ^ 5'b00101) : {c[3:0], 1'b0};
    end
    return ~c;
  endfunction

  function automatic logic is_token(input logic [3:0] pid);
    case (pid)
      PID_OUT, PID_IN, PID_SOF, PID_SETUP: is_token = 1'b1;
      default:                             is_token = 1'b0;
    endcase
  endfunction

  state_t          state_r, state_s;
  logic [3:0]      pid_r, pid_s;
  logic [7:0]      byte1_r, byte1_s;
  logic [CW-1:0]   cnt_r, cnt_s;

  logic            accept_s;
  logic            err_pid_s, err_crc_s, err_len_s, err_endp_s, err_timeout_s;
  logic [3:0]      tok_pid_s;
  logic [6:0]      tok_addr_s;
  logic [3:0]      tok_endp_s;
  logic [10:0]     tok_frame_s;
  logic            tok_sof_s;
  logic [NUM_EP-1:0] tok_ep_sel_s;
  logic [NUM_EP-1:0] ep_onehot_s;

  logic [10:0]     frame_s;
  logic [3:0]      endp_s;
  logic [6:0]      addr_s;
  logic            crc_ok_s;
  logic            endp_bad_s;
  logic            pid_chk_ok_s;
  logic            is_sof_s;

  // Candidate token fields while byte2 is on the bus
  assign frame_s      = {rx_byte[2:0], byte1_r};
  assign endp_s       = frame_s[10:7];
  assign addr_s       = byte1_r[6:0];
  assign crc_ok_s     = (rx_byte[7:3] == crc5_calc(frame_s));
  assign endp_bad_s   = ({1'b0, endp_s} >= 5'(NUM_EP));
  assign pid_chk_ok_s = (rx_byte[7:4] == ~rx_byte[3:0]);
  assign is_sof_s     = (pid_r == PID_SOF);

  // One-hot endpoint decode of the candidate token
  always_comb begin
    ep_onehot_s = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      ep_onehot_s[i] = (endp_s == 4'(i));
    end
  end

  // Next state, inter-byte timer and strobe decision for the current cycle
  always_comb begin
    state_s       = state_r;
    pid_s         = pid_r;
    byte1_s       = byte1_r;
    cnt_s         = cnt_r;
    accept_s      = 1'b0;
    err_pid_s     = 1'b0;
    err_crc_s     = 1'b0;
    err_len_s     = 1'b0;
    err_endp_s    = 1'b0;
    err_timeout_s = 1'b0;
    if (rx_valid) begin
      cnt_s = '0;
      case (state_r)
        IDLE: begin
          if (!pid_chk_ok_s) begin
            err_pid_s = 1'b1;
            state_s   = rx_eop ? IDLE : DRAIN;
          end else if (!is_token(rx_byte[3:0])) begin
            state_s = rx_eop ? IDLE : DRAIN;
          end else if (rx_eop) begin
            err_len_s = 1'b1;
            state_s   = IDLE;
          end else begin
            pid_s   = rx_byte[3:0];
            state_s = ADDR;
          end
        end
        ADDR: begin
          if (rx_eop) begin
            err_len_s = 1'b1;
            state_s   = IDLE;
          end else begin
            byte1_s = rx_byte;
            state_s = CRC;
          end
        end
        CRC: begin
          if (!rx_eop) begin
            err_len_s = 1'b1;
            state_s   = DRAIN;
          end else begin
            state_s = IDLE;
            if (!crc_ok_s) begin
              err_crc_s = 1'b1;
            end else if (is_sof_s) begin
              accept_s = 1'b1;
            end else if (addr_s != dev_addr) begin
              accept_s = 1'b0;  // another device's token: dropped without a strobe
            end else if (endp_bad_s) begin
              err_endp_s = 1'b1;
            end else begin
              accept_s = 1'b1;
            end
          end
        end
        DRAIN: begin
          state_s = rx_eop ? IDLE : DRAIN;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else if (state_r != IDLE) begin
      if (cnt_r == CW'(TIMEOUT - 1)) begin
        err_timeout_s = 1'b1;
        state_s       = IDLE;
        cnt_s         = '0;
      end else begin
        cnt_s = cnt_r + CW'(1);
      end
    end else begin
      cnt_s = '0;
    end
  end

  // Output fields: load on an accepted token, otherwise hold the previous one
  always_comb begin
    tok_pid_s    = tok_pid;
    tok_addr_s   = tok_addr;
    tok_endp_s   = tok_endp;
    tok_frame_s  = tok_frame;
    tok_sof_s    = tok_sof;
    tok_ep_sel_s = tok_ep_sel;
    if (accept_s) begin
      tok_pid_s    = pid_r;
      tok_addr_s   = addr_s;
      tok_endp_s   = endp_s;
      tok_sof_s    = is_sof_s;
      tok_frame_s  = is_sof_s ? frame_s : 11'd0;
      tok_ep_sel_s = is_sof_s ? '0 : ep_onehot_s;
    end else begin
      tok_sof_s    = tok_sof;
    end
  end

  // State, timer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      pid_r       <= 4'd0;
      byte1_r     <= 8'd0;
      cnt_r       <= '0;
      tok_valid   <= 1'b0;
      tok_pid     <= 4'd0;
      tok_addr    <= 7'd0;
      tok_endp    <= 4'd0;
      tok_frame   <= 11'd0;
      tok_sof     <= 1'b0;
      tok_ep_sel  <= '0;
      err_pid     <= 1'b0;
      err_crc     <= 1'b0;
      err_len     <= 1'b0;
      err_endp    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_r     <= state_s;
      pid_r       <= pid_s;
      byte1_r     <= byte1_s;
      cnt_r       <= cnt_s;
      tok_valid   <= accept_s;
      tok_pid     <= tok_pid_s;
      tok_addr    <= tok_addr_s;
      tok_endp    <= tok_endp_s;
      tok_frame   <= tok_frame_s;
      tok_sof     <= tok_sof_s;
      tok_ep_sel  <= tok_ep_sel_s;
      err_pid     <= err_pid_s;
      err_crc     <= err_crc_s;
      err_len     <= err_len_s;
      err_endp    <= err_endp_s;
      err_timeout <= err_timeout_s;
    end
  end

endmodule
